// File: rtl/adex_pkg.sv
// rtl/adex_pkg.sv - shared types and constants for the AdEx config sequencer
`timescale 1ns/1ps
package adex_pkg;

  localparam int N_PARAMS = 8;
  localparam int PW       = 16;
  localparam int AW       = $clog2(N_PARAMS);

  localparam logic [3:0] CFG_MAGIC = 4'hA;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2,
    WR   = 2'd3
  } state_t;

  // A header byte carries the magic nibble and a clear reserved bit
  function automatic logic is_header(input logic [7:0] b);
    return (b[7:4] == CFG_MAGIC) && !b[3];
  endfunction

endpackage

// File: rtl/adex_step_timer.sv
// rtl/adex_step_timer.sv - integration-step period counter with registered request
`timescale 1ns/1ps
module adex_step_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run_en,
  input  logic [7:0] prescale,
  output logic       req
);

  logic [7:0] cnt;

  // Count 0..prescale; the terminal count becomes a request one cycle later.
  // prescale is live, so a counter left above a freshly lowered prescale
  // simply wraps to 0 without producing a request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      req <= 1'b0;
    end else if (!run_en) begin
      cnt <= '0;
      req <= 1'b0;
    end else begin
      req <= (cnt == prescale);
      if (cnt >= prescale) cnt <= '0;
      else                 cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/adex_cfg_sequencer.sv
// rtl/adex_cfg_sequencer.sv - config frame sequencer and step strobe for the AdEx core
`timescale 1ns/1ps
module adex_cfg_sequencer
  import adex_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [7:0]    cfg_byte,
  input  logic          run_en,
  input  logic [7:0]    prescale,
  output logic          prm_we,
  output logic [AW-1:0] prm_addr,
  output logic [PW-1:0] prm_wdata,
  output logic          step,
  output logic          busy,
  output logic          frame_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] IDLE_LAST = CW'(TIMEOUT - 1);

  state_t        state;
  logic [CW-1:0] idle_cnt;
  logic [AW-1:0] addr_q;
  logic [7:0]    hi_q;
  logic          pending;
  logic          step_req;
  logic          hs;
  logic          timed_out;

  assign cfg_ready = (state != WR);
  assign busy      = (state != IDLE);
  assign hs        = cfg_valid && cfg_ready;
  assign timed_out = (idle_cnt == IDLE_LAST);

  // Step fires only in IDLE, while prm_we is only ever high in WR, so the two
  // strobes cannot coincide and a step never sees a half-written parameter set.
  assign step = (state == IDLE) && (step_req || pending);

  adex_step_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .run_en   (run_en),
    .prescale (prescale),
    .req      (step_req)
  );

  // Frame FSM: header -> MSB -> LSB -> one-cycle write, with inter-byte timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idle_cnt  <= '0;
      addr_q    <= '0;
      hi_q      <= '0;
      prm_we    <= 1'b0;
      prm_addr  <= '0;
      prm_wdata <= '0;
      frame_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          idle_cnt <= '0;
          if (hs) begin
            if (is_header(cfg_byte)) begin
              addr_q <= cfg_byte[AW-1:0];
              state  <= HI;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        HI: begin
          if (hs) begin
            hi_q     <= cfg_byte;
            idle_cnt <= '0;
            state    <= LO;
          end else if (timed_out) begin
            frame_err <= 1'b1;
            idle_cnt  <= '0;
            state     <= IDLE;
          end else begin
            idle_cnt <= idle_cnt + CW'(1);
          end
        end
        LO: begin
          if (hs) begin
            prm_addr  <= addr_q;
            prm_wdata <= {hi_q, cfg_byte};
            prm_we    <= 1'b1;
            idle_cnt  <= '0;
            state     <= WR;
          end else if (timed_out) begin
            frame_err <= 1'b1;
            idle_cnt  <= '0;
            state     <= IDLE;
          end else begin
            idle_cnt <= idle_cnt + CW'(1);
          end
        end
        WR: begin
          prm_we <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          prm_we <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  // Hold at most one step request that lands while a frame is in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
    end else if (!run_en) begin
      pending <= 1'b0;
    end else if (state == IDLE) begin
      pending <= 1'b0;
    end else if (step_req) begin
      pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adex_cfg_sequencer.sv
// tb/tb_adex_cfg_sequencer.sv - directed self-checking bench for adex_cfg_sequencer
`timescale 1ns/1ps
module tb_adex_cfg_sequencer;
  import adex_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [7:0]    cfg_byte = 8'h00;
  logic          run_en = 1'b0;
  logic [7:0]    prescale = 8'h00;
  logic          prm_we;
  logic [AW-1:0] prm_addr;
  logic [PW-1:0] prm_wdata;
  logic          step;
  logic          busy;
  logic          frame_err;

  int n_chk = 0;
  int n_pass = 0;
  int we_cnt = 0;
  int both_cnt = 0;
  logic [AW-1:0] last_addr = '0;
  logic [PW-1:0] last_data = '0;

  always #5 clk = ~clk;

  adex_cfg_sequencer #(.TIMEOUT(255)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_byte  (cfg_byte),
    .run_en    (run_en),
    .prescale  (prescale),
    .prm_we    (prm_we),
    .prm_addr  (prm_addr),
    .prm_wdata (prm_wdata),
    .step      (step),
    .busy      (busy),
    .frame_err (frame_err)
  );

  always @(negedge clk) begin
    if (rst_n) begin
      if (prm_we) begin
        we_cnt++;
        last_addr = prm_addr;
        last_data = prm_wdata;
      end
      if (step && prm_we) both_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_byte = 8'h00; run_en = 1'b0; prescale = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Offer one byte and return #1 after the edge that transfers it; valid stays high
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    cfg_valid = 1'b1;
    cfg_byte  = b;
    @(negedge clk);
    while (!cfg_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cfg_ready) chk("send_ready_wait", 32'(cfg_ready), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    cfg_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(cfg_ready), 32'd1);
    chk({tag, "_busy"},  32'(busy),      32'd0);
    chk({tag, "_we"},    32'(prm_we),    32'd0);
    chk({tag, "_step"},  32'(step),      32'd0);
    chk({tag, "_err"},   32'(frame_err), 32'd0);
    chk({tag, "_addr"},  32'(prm_addr),  32'd0);
    chk({tag, "_wdata"}, 32'(prm_wdata), 32'd0);
  endtask

  initial begin
    int base;
    logic [7:0] t5 [1:3];

    // 1: basic frame, write one cycle after the LSB handshake
    do_reset();
    chk_reset_outputs("rst");
    send(8'hA3); send(8'h12); send(8'h34);
    cfg_valid = 1'b0;
    chk("t1_we",    32'(prm_we),    32'd1);
    chk("t1_ready", 32'(cfg_ready), 32'd0);
    chk("t1_addr",  32'(prm_addr),  32'd3);
    chk("t1_wdata", 32'(prm_wdata), 32'h1234);
    chk("t1_err",   32'(frame_err), 32'd0);
    @(posedge clk); #1;
    chk("t1_we_one_cycle", 32'(prm_we), 32'd0);
    chk("t1_busy_done",    32'(busy),   32'd0);
    idle(2);
    chk("t1_we_count", 32'(we_cnt), 32'd1);

    // 2: bad header is dropped, following frames still land; byte offered during WR waits
    send(8'h55);
    idle(2);
    chk("t2_err",      32'(frame_err), 32'd1);
    chk("t2_busy",     32'(busy),      32'd0);
    chk("t2_we_count", 32'(we_cnt),    32'd1);
    send(8'hA0); send(8'hBE); send(8'hEF);
    chk("t2_addr",  32'(prm_addr),  32'd0);
    chk("t2_wdata", 32'(prm_wdata), 32'hBEEF);
    send(8'hA4); send(8'h56); send(8'h78);
    idle(3);
    chk("t2_we_count2", 32'(we_cnt),    32'd3);
    chk("t2_last_addr", 32'(last_addr), 32'd4);
    chk("t2_last_data", 32'(last_data), 32'h5678);

    // 3: inter-byte timeout after the MSB byte
    do_reset();
    base = we_cnt;
    send(8'hA1); send(8'h00);
    cfg_valid = 1'b0;
    repeat (254) @(posedge clk);
    #1;
    chk("t3_busy_254", 32'(busy),      32'd1);
    chk("t3_err_254",  32'(frame_err), 32'd0);
    @(posedge clk); #1;
    chk("t3_busy_255", 32'(busy),      32'd0);
    chk("t3_err_255",  32'(frame_err), 32'd1);
    chk("t3_no_we",    32'(we_cnt - base), 32'd0);
    send(8'hA1); send(8'hCA); send(8'hFE);
    idle(2);
    chk("t3_we_count", 32'(we_cnt - base), 32'd1);
    chk("t3_addr",     32'(last_addr),     32'd1);
    chk("t3_wdata",    32'(last_data),     32'hCAFE);

    // 4: step cadence for prescale 3, prescale 0, disabled, and a live prescale drop
    do_reset();
    run_en = 1'b1; prescale = 8'd3;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      chk("t4_ps3_step", 32'(step), 32'((k % 4) == 0));
    end
    prescale = 8'd0;
    for (int k = 13; k <= 17; k++) begin
      @(posedge clk); #1;
      chk("t4_ps0_step", 32'(step), 32'd1);
    end
    run_en = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk("t4_off_step", 32'(step), 32'd0);
    end
    run_en = 1'b1; prescale = 8'd7;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k == 5) prescale = 8'd2;
      chk("t4_wrap_step", 32'(step), 32'(k == 9));
    end
    run_en = 1'b0;

    // 5: terminal count lands during WR; step is deferred to the first IDLE cycle
    do_reset();
    t5[1] = 8'hA2; t5[2] = 8'h55; t5[3] = 8'hAA;
    run_en = 1'b1; prescale = 8'd3;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      if (k <= 3) begin
        cfg_valid = 1'b1;
        cfg_byte  = t5[k];
      end else begin
        cfg_valid = 1'b0;
      end
      chk("t5_step", 32'(step),   32'(k == 5));
      chk("t5_we",   32'(prm_we), 32'(k == 4));
    end
    run_en = 1'b0;
    idle(2);
    chk("t5_last_data", 32'(last_data), 32'h55AA);

    // 6: reset in the middle of a frame
    do_reset();
    send(8'hA5); send(8'h11);
    cfg_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("t6_mid");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    base = we_cnt;
    send(8'h66); send(8'h77);
    idle(3);
    chk("t6_no_partial_we", 32'(we_cnt - base), 32'd0);
    chk("t6_err_dropped",   32'(frame_err),     32'd1);
    send(8'hA5); send(8'h66); send(8'h77);
    idle(2);
    chk("t6_we_count", 32'(we_cnt - base), 32'd1);
    chk("t6_addr",     32'(last_addr),     32'd5);
    chk("t6_wdata",    32'(last_data),     32'h6677);

    chk("never_step_with_we", 32'(both_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
